nrz_to_biphase: RTL and testbench
=================================

Name: nrz_to_biphase

Overview:
Transmit-side line encoder for the multi-mode demod test path. It takes a hard NRZ bit stream through a valid/ready handshake and emits NRZ-L, Biphase-L, Biphase-M or Biphase-S at half-symbol rate. Output is both a hard level and a signed soft symbol, so it can drive the bit sync and biphase decoder directly in loopback and BIST.

Parameters:
SOFT_W, 3, width of signed soft symbol output
SOFT_MAG, 3, magnitude of soft symbol; level 1 -> +SOFT_MAG, level 0 -> -SOFT_MAG (two's complement)

Ports:
clk  input  1  system clock; single clock domain
rs  input  1  reset, synchronous, active-high
half_clk_en  input  1  strobe, two per bit period (one per half-symbol)
mode  input  2  00 NRZ-L, 01 Biphase-L, 10 Biphase-M, 11 Biphase-S
invert  input  1  invert data bit before encoding
bit_valid  input  1  upstream bit available
bit_in  input  1  NRZ data bit
bit_ready  output  1  hold register empty; bit accepted when bit_valid & bit_ready
sym_out  output  1  encoded line level for current half-symbol
sym_soft  output  SOFT_W  signed soft version of sym_out
sym_en  output  1  one-cycle strobe; sym_out/sym_soft updated this cycle
first_half  output  1  1 while the first half of a bit is on the output
underflow  output  1  sticky: a bit boundary found no data
clr_underflow  input  1  clears underflow

Behaviour:
- Reset (sync, rs=1 at clk edge), from the next cycle: sym_out=0, sym_soft=0, sym_en=0, first_half=0, underflow=0, hold empty (bit_ready=1), level reg lvl=0, mode_r=00, phase=second-half, so the first half_clk_en is a bit boundary. Reset mid-bit discards the hold and current bits.
- Hold register: 1 entry. bit_ready = ~hold_full (combinational from register only). Accept on bit_valid & bit_ready.
- Bit boundary = half_clk_en while phase=second-half:
  - Hold full: cur_bit <- hold ^ invert, hold emptied.
  - Hold empty and bit_valid: bypass. cur_bit <- bit_in ^ invert, bit consumed this cycle, hold stays empty.
  - Neither: cur_bit <- 0 ^ invert (idle bit), underflow <- 1.
  - mode_r <- mode. Mode is sampled only at boundaries; a mid-bit change has no effect until the next bit.
- Mid-bit = half_clk_en while phase=first-half: second-half level output.
- Encoding, b=cur_bit, registered outputs valid in the cycle after the half_clk_en:
  - NRZ-L: halves b, b.
  - Biphase-L: halves b, ~b.
  - Biphase-M: lvl toggles at bit start (first half = ~lvl_prev); toggles again at mid-bit if b=1.
  - Biphase-S: toggles at bit start; toggles at mid-bit if b=0.
  - lvl always holds the last output level. In NRZ/Biphase-L, lvl tracks sym_out so a switch into M/S is continuous.
- sym_en asserted exactly one cycle after each half_clk_en; otherwise 0. first_half=1 when the emitted half is the first.
- sym_soft = sym_out ? SOFT_MAG : -SOFT_MAG, truncated to SOFT_W bits; 0 only while reset.
- Latency: bit in hold at a boundary strobe appears on sym_out 1 clk later.
- underflow: set and clr_underflow in the same cycle -> set wins. Otherwise clr_underflow clears it.
- half_clk_en consecutive cycles is legal; each strobe advances one half.

Optional Feature:
NRZ2BP_PN15_EN
- Defined: adds input pn_sel (1 bit). When pn_sel=1, bits come from an internal PN15 LFSR (x^15+x^14+1, Fibonacci, seed all ones at reset, output = MSB), advanced at each bit boundary. In this mode bit_ready=0, the hold is untouched and underflow is never set. invert and mode still apply.
- Not defined: no pn_sel port, no LFSR logic; data comes only from the handshake.

Test Plan:
- Biphase-L, invert=0, bits 1,0 preloaded -> sym_out halves 1,0,0,1; sym_soft +3,-3,-3,+3; first_half 1,0,1,0.
- Biphase-M from reset (lvl=0), bits 1,1,0 -> halves 1,0,1,0,1,1.
- Biphase-S from reset, bits 0,1 -> halves 1,0,1,1; with invert=1, the same bits give 0,1 at bit 0 start... -> halves 1,1,0,1.
- Backpressure: hold bit 1 with bit_valid held high -> bit_ready=0 until the boundary; a second bit is accepted 1 clk after. Bypass: hold empty and bit_valid=1 on the boundary cycle -> bit encoded immediately, bit_ready stays 1.
- Underflow: NRZ-L, no data at a boundary -> halves 0,0, underflow=1. Assert clr_underflow on a cycle with another starved boundary -> underflow stays 1; clear on a quiet cycle -> 0.
- Reset mid-bit during Biphase-M -> outputs 0 next cycle. The first strobe after reset is a boundary; the encoding restarts from lvl=0. With NRZ2BP_PN15_EN, pn_sel=1, NRZ-L -> first 15 bits all 1, bit_ready=0.

Source files
------------

// File: rtl/nrz_to_biphase.sv
// NRZ to NRZ-L / Biphase-L/M/S line encoder with hard and signed soft symbol outputs.
// Optional PN15 data source enabled by defining NRZ2BP_PN15_EN (adds pn_sel input).
module nrz_to_biphase #(
    parameter int SOFT_W   = 3,
    parameter int SOFT_MAG = 3
) (
    input  logic                     clk,
    input  logic                     rs,
    input  logic                     half_clk_en,
    input  logic [1:0]               mode,
    input  logic                     invert,
    input  logic                     bit_valid,
    input  logic                     bit_in,
`ifdef NRZ2BP_PN15_EN
    input  logic                     pn_sel,
`endif
    output logic                     bit_ready,
    output logic                     sym_out,
    output logic signed [SOFT_W-1:0] sym_soft,
    output logic                     sym_en,
    output logic                     first_half,
    output logic                     underflow,
    input  logic                     clr_underflow
);

    localparam logic PH_FIRST  = 1'b1;
    localparam logic PH_SECOND = 1'b0;

    localparam logic [1:0] M_NRZL = 2'b00;
    localparam logic [1:0] M_BPL  = 2'b01;
    localparam logic [1:0] M_BPM  = 2'b10;
    localparam logic [1:0] M_BPS  = 2'b11;

    localparam logic signed [SOFT_W-1:0] SOFT_POS = SOFT_W'(SOFT_MAG);
    localparam logic signed [SOFT_W-1:0] SOFT_NEG = SOFT_W'(-SOFT_MAG);

    logic       phase;
    logic       hold_full;
    logic       hold_bit;
    logic       cur_bit;
    logic [1:0] mode_r;
    logic       lvl;
    logic       pn_active;
    logic       boundary;
    logic       accept;
    logic       src_bit;
    logic       starve;
    logic       enc_bit;
    logic       nxt_lvl;

`ifdef NRZ2BP_PN15_EN
    logic [14:0] lfsr;
    assign pn_active = pn_sel;
`else
    assign pn_active = 1'b0;
`endif

    assign boundary  = half_clk_en & (phase == PH_SECOND);
    assign bit_ready = ~hold_full & ~pn_active;
    assign accept    = bit_valid & bit_ready;
    assign sym_out   = lvl;

    always_comb begin
        src_bit = 1'b0;
        starve  = 1'b0;
        if (pn_active) begin
`ifdef NRZ2BP_PN15_EN
            src_bit = lfsr[14];
`endif
        end else if (hold_full) begin
            src_bit = hold_bit;
        end else if (bit_valid) begin
            src_bit = bit_in;
        end else begin
            starve = 1'b1;
        end
        enc_bit = src_bit ^ invert;
    end

    // Bit start uses the freshly sampled mode; mid-bit uses the mode latched at the boundary.
    always_comb begin
        nxt_lvl = lvl;
        if (boundary) begin
            case (mode)
                M_NRZL, M_BPL: nxt_lvl = enc_bit;
                default:       nxt_lvl = ~lvl;
            endcase
        end else begin
            case (mode_r)
                M_NRZL:  nxt_lvl = cur_bit;
                M_BPL:   nxt_lvl = ~cur_bit;
                M_BPM:   nxt_lvl = cur_bit ? ~lvl : lvl;
                M_BPS:   nxt_lvl = cur_bit ? lvl : ~lvl;
                default: nxt_lvl = lvl;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            phase      <= PH_SECOND;
            hold_full  <= 1'b0;
            hold_bit   <= 1'b0;
            cur_bit    <= 1'b0;
            mode_r     <= M_NRZL;
            lvl        <= 1'b0;
            sym_soft   <= '0;
            sym_en     <= 1'b0;
            first_half <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            sym_en <= half_clk_en;
            if (half_clk_en) begin
                lvl        <= nxt_lvl;
                sym_soft   <= nxt_lvl ? SOFT_POS : SOFT_NEG;
                first_half <= boundary;
                phase      <= boundary ? PH_FIRST : PH_SECOND;
            end
            if (boundary) begin
                cur_bit <= enc_bit;
                mode_r  <= mode;
            end
            // Accept on a boundary with an empty hold is the bypass path: the bit is encoded directly.
            if (boundary && !pn_active && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept && !boundary) begin
                hold_full <= 1'b1;
                hold_bit  <= bit_in;
            end
            if (boundary && starve) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef NRZ2BP_PN15_EN
    always_ff @(posedge clk) begin
        if (rs) begin
            lfsr <= '1;
        end else if (boundary && pn_active) begin
            lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        end
    end
`endif

endmodule

// File: tb/tb_nrz_to_biphase.sv
// Directed and randomized checks of nrz_to_biphase against a half-symbol reference model.
module tb_nrz_to_biphase;

    localparam int SOFT_W   = 3;
    localparam int SOFT_MAG = 3;

    logic              clk = 1'b0;
    logic              rs = 1'b1;
    logic              half_clk_en = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              invert = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_ready;
    logic              sym_out;
    logic [SOFT_W-1:0] sym_soft;
    logic              sym_en;
    logic              first_half;
    logic              underflow;
    logic              clr_underflow = 1'b0;
`ifdef NRZ2BP_PN15_EN
    logic              pn_sel = 1'b0;
`endif

    int nchk  = 0;
    int nfail = 0;
    logic model_lvl = 1'b0;

    nrz_to_biphase #(.SOFT_W(SOFT_W), .SOFT_MAG(SOFT_MAG)) dut (
        .clk           (clk),
        .rs            (rs),
        .half_clk_en   (half_clk_en),
        .mode          (mode),
        .invert        (invert),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
`ifdef NRZ2BP_PN15_EN
        .pn_sel        (pn_sel),
`endif
        .bit_ready     (bit_ready),
        .sym_out       (sym_out),
        .sym_soft      (sym_soft),
        .sym_en        (sym_en),
        .first_half    (first_half),
        .underflow     (underflow),
        .clr_underflow (clr_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SOFT_W-1:0] soft_of(input logic h);
        int v;
        v = h ? SOFT_MAG : (1 << SOFT_W) - SOFT_MAG;
        return v[SOFT_W-1:0];
    endfunction

    // Reference: the two half levels of one bit, given the previous line level.
    task automatic model_bit(input logic [1:0] m, input logic b, output logic h1, output logic h2);
        case (m)
            2'd0: begin h1 = b; h2 = b; end
            2'd1: begin h1 = b; h2 = !b; end
            2'd2: begin h1 = !model_lvl; h2 = h1 ^ b; end
            default: begin h1 = !model_lvl; h2 = h1 ^ !b; end
        endcase
        model_lvl = h2;
    endtask

    task automatic expect_half(input string tag, input logic h, input logic fh);
        chk({tag, "_sym_out"}, {7'd0, sym_out}, {7'd0, h});
        chk({tag, "_sym_soft"}, {5'd0, sym_soft}, {5'd0, soft_of(h)});
        chk({tag, "_sym_en"}, {7'd0, sym_en}, 8'd1);
        chk({tag, "_first_half"}, {7'd0, first_half}, {7'd0, fh});
    endtask

    task automatic strobe();
        half_clk_en = 1'b1;
        tick();
        half_clk_en = 1'b0;
    endtask

    task automatic do_reset();
        rs = 1'b1;
        half_clk_en = 1'b0;
        bit_valid = 1'b0;
        clr_underflow = 1'b0;
        tick();
        rs = 1'b0;
        model_lvl = 1'b0;
        chk("rst_sym_out", {7'd0, sym_out}, 8'd0);
        chk("rst_sym_soft", {5'd0, sym_soft}, 8'd0);
        chk("rst_sym_en", {7'd0, sym_en}, 8'd0);
        chk("rst_first_half", {7'd0, first_half}, 8'd0);
        chk("rst_underflow", {7'd0, underflow}, 8'd0);
        chk("rst_bit_ready", {7'd0, bit_ready}, 8'd1);
    endtask

    task automatic run_bit(input string tag, input logic [1:0] m, input logic b,
                           input logic preload, input int gap);
        logic h1, h2;
        bit_in = b;
        if (preload) begin
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            chk({tag, "_held_ready"}, {7'd0, bit_ready}, 8'd0);
        end else begin
            bit_valid = 1'b1;
        end
        mode = m;
        strobe();
        bit_valid = 1'b0;
        model_bit(m, b ^ invert, h1, h2);
        expect_half({tag, "_h1"}, h1, 1'b1);
        chk({tag, "_ready_after"}, {7'd0, bit_ready}, 8'd1);
        mode = 2'($urandom_range(0, 3));
        if (gap > 0) begin
            repeat (gap) tick();
            chk({tag, "_sym_en_idle"}, {7'd0, sym_en}, 8'd0);
        end
        strobe();
        expect_half({tag, "_h2"}, h2, 1'b0);
        repeat (gap) tick();
    endtask

    initial begin
        logic h1, h2;

        do_reset();

        // Biphase-L, bits 1,0 preloaded: 1,0,0,1
        invert = 1'b0;
        run_bit("bpl_b1", 2'd1, 1'b1, 1'b1, 1);
        run_bit("bpl_b0", 2'd1, 1'b0, 1'b1, 1);

        // Biphase-M from reset, bits 1,1,0: 1,0,1,0,1,1
        do_reset();
        run_bit("bpm_b1a", 2'd2, 1'b1, 1'b0, 0);
        run_bit("bpm_b1b", 2'd2, 1'b1, 1'b0, 1);
        run_bit("bpm_b0", 2'd2, 1'b0, 1'b0, 2);

        // Biphase-S from reset, bits 0,1, then inverted
        do_reset();
        run_bit("bps_b0", 2'd3, 1'b0, 1'b0, 1);
        run_bit("bps_b1", 2'd3, 1'b1, 1'b0, 1);
        do_reset();
        invert = 1'b1;
        run_bit("bps_inv_b0", 2'd3, 1'b0, 1'b0, 1);
        run_bit("bps_inv_b1", 2'd3, 1'b1, 1'b1, 0);
        invert = 1'b0;

        // Backpressure: second bit held off until the boundary frees the hold
        do_reset();
        mode = 2'd1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        chk("bp_ready_full", {7'd0, bit_ready}, 8'd0);
        bit_in = 1'b0;
        repeat (2) tick();
        chk("bp_ready_held", {7'd0, bit_ready}, 8'd0);
        strobe();
        model_bit(2'd1, 1'b1, h1, h2);
        expect_half("bp_b1_h1", h1, 1'b1);
        chk("bp_ready_freed", {7'd0, bit_ready}, 8'd1);
        tick();
        chk("bp_second_accept", {7'd0, bit_ready}, 8'd0);
        bit_valid = 1'b0;
        strobe();
        expect_half("bp_b1_h2", h2, 1'b0);
        strobe();
        model_bit(2'd1, 1'b0, h1, h2);
        expect_half("bp_b0_h1", h1, 1'b1);
        chk("bp_ready_final", {7'd0, bit_ready}, 8'd1);
        strobe();
        expect_half("bp_b0_h2", h2, 1'b0);

        // Underflow: starved NRZ-L boundary, set-wins-over-clear, then clear
        do_reset();
        mode = 2'd0;
        strobe();
        expect_half("uf_h1", 1'b0, 1'b1);
        chk("uf_set", {7'd0, underflow}, 8'd1);
        strobe();
        expect_half("uf_h2", 1'b0, 1'b0);
        clr_underflow = 1'b1;
        strobe();
        chk("uf_set_wins", {7'd0, underflow}, 8'd1);
        tick();
        clr_underflow = 1'b0;
        chk("uf_cleared", {7'd0, underflow}, 8'd0);
        strobe();

        // Reset mid-bit in Biphase-M with a bit waiting in the hold
        do_reset();
        mode = 2'd2;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        strobe();
        chk("mid_rst_pre", {7'd0, sym_out}, 8'd1);
        bit_in = 1'b0;
        tick();
        bit_valid = 1'b0;
        chk("mid_rst_hold_full", {7'd0, bit_ready}, 8'd0);
        do_reset();
        run_bit("post_rst_b0", 2'd2, 1'b0, 1'b0, 1);

        // Randomized bits, modes, inversion, preload/bypass and strobe spacing
        do_reset();
        for (int i = 0; i < 40; i++) begin
            invert = 1'($urandom_range(0, 1));
            run_bit($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
        end
        chk("rnd_no_underflow", {7'd0, underflow}, 8'd0);
        invert = 1'b0;

`ifdef NRZ2BP_PN15_EN
        do_reset();
        pn_sel = 1'b1;
        mode = 2'd0;
        for (int i = 0; i < 15; i++) begin
            strobe();
            chk($sformatf("pn%0d_h1", i), {7'd0, sym_out}, 8'd1);
            chk($sformatf("pn%0d_ready", i), {7'd0, bit_ready}, 8'd0);
            strobe();
            chk($sformatf("pn%0d_h2", i), {7'd0, sym_out}, 8'd1);
        end
        chk("pn_no_underflow", {7'd0, underflow}, 8'd0);
        pn_sel = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
